// File: rtl/paint_pkg.sv
// paint_pkg: shared state type, screen geometry and step/brush size decoding for the paint pipeline.
package paint_pkg;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int SCR_W_DEF = 640;
    localparam int SCR_H_DEF = 480;
    typedef enum logic [1:0] {IDLE, STAMP, CLEAR} cb_state_t;
    function automatic logic [4:0] step_px(input logic [1:0] sel);
        return sel == 2'd0 ? 5'd1 : sel == 2'd1 ? 5'd2 : sel == 2'd2 ? 5'd10 : 5'd20;
    endfunction
    function automatic logic [3:0] brush_px(input logic [1:0] sel);
        return 4'd1 << sel;
    endfunction
endpackage

// File: rtl/raster_scan.sv
// raster_scan: 2-D row-major counter; latches width/height on start, flags the last coordinate with done.
module raster_scan import paint_pkg::*; (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    output logic [XW-1:0] dx,
    output logic [YW-1:0] dy,
    output logic          done
);
    logic run;
    logic last_x;
    logic [XW-1:0] wl;
    logic [YW-1:0] hl;
    assign last_x = dx == wl - 1'b1;
    assign done = run && last_x && dy == hl - 1'b1;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run <= 1'b0;
            dx  <= '0;
            dy  <= '0;
            wl  <= '0;
            hl  <= '0;
        end else if (start) begin
            run <= 1'b1;
            dx  <= '0;
            dy  <= '0;
            wl  <= w;
            hl  <= h;
        end else if (run) begin
            dx  <= last_x ? '0 : dx + 1'b1;
            dy  <= last_x ? dy + 1'b1 : dy;
            run <= !done;
        end
    end
endmodule

// File: rtl/cursor_brush.sv
// cursor_brush: clamped cursor with square-brush stamping onto the framebuffer write port.
// Define CURSOR_BRUSH_CLEAR_EN to add the full-screen clear sweep on clear_req.
module cursor_brush import paint_pkg::*; #(
    parameter int SCR_W = SCR_W_DEF,
    parameter int SCR_H = SCR_H_DEF,
    parameter int X_RST = 200,
    parameter int Y_RST = 200
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          up,
    input  logic          down,
    input  logic          left,
    input  logic          right,
    input  logic [1:0]    step_sel,
    input  logic [1:0]    brush_sel,
    input  logic          draw_en,
    input  logic          color_in,
    input  logic          clear_req,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          pixel_color,
    output logic          pixel_write,
    output logic [XW-1:0] cursor_x,
    output logic [YW-1:0] cursor_y,
    output logic          busy
);
    localparam logic signed [XW:0] X_MAX = (XW+1)'(SCR_W - 1);
    localparam logic signed [YW:0] Y_MAX = (YW+1)'(SCR_H - 1);
    localparam logic [XW:0] X_LIM = (XW+1)'(SCR_W);
    localparam logic [YW:0] Y_LIM = (YW+1)'(SCR_H);
    cb_state_t state, state_nx;
    logic clr_go, accept, scan_done, color_q;
    logic [XW-1:0] dx, scan_w, cx_nx;
    logic [YW-1:0] dy, scan_h, cy_nx;
    logic [4:0] step;
    logic signed [XW:0] stx, nx;
    logic signed [YW:0] sty, ny;
    logic [XW:0] px;
    logic [YW:0] py;
`ifdef CURSOR_BRUSH_CLEAR_EN
    assign clr_go = state == IDLE && clear_req;
`else
    logic unused_clear;
    assign unused_clear = clear_req;
    assign clr_go = 1'b0;
`endif
    assign accept = state == IDLE && (up || down || left || right) && !clr_go;
    assign busy = state != IDLE;
    assign step = step_px(step_sel);
    assign stx = signed'({{(XW-4){1'b0}}, step});
    assign sty = signed'({{(YW-4){1'b0}}, step});
    // Signed intermediates let a step past the origin go negative before clamping.
    assign nx = signed'({1'b0, cursor_x}) + (right ? stx : '0) - (left ? stx : '0);
    assign ny = signed'({1'b0, cursor_y}) + (down ? sty : '0) - (up ? sty : '0);
    assign cx_nx = nx[XW] ? '0 : nx > X_MAX ? X_MAX[XW-1:0] : nx[XW-1:0];
    assign cy_nx = ny[YW] ? '0 : ny > Y_MAX ? Y_MAX[YW-1:0] : ny[YW-1:0];
    assign scan_w = clr_go ? XW'(SCR_W) : XW'(brush_px(brush_sel));
    assign scan_h = clr_go ? YW'(SCR_H) : YW'(brush_px(brush_sel));
    assign px = (state == STAMP ? {1'b0, cursor_x} : '0) + {1'b0, dx};
    assign py = (state == STAMP ? {1'b0, cursor_y} : '0) + {1'b0, dy};
    raster_scan u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (clr_go || (accept && draw_en)),
        .w       (scan_w),
        .h       (scan_h),
        .dx      (dx),
        .dy      (dy),
        .done    (scan_done)
    );
    always_comb begin
        state_nx = state;
`ifdef CURSOR_BRUSH_CLEAR_EN
        if (clr_go)
            state_nx = CLEAR;
        else
`endif
        if (accept && draw_en)
            state_nx = STAMP;
        else if (state != IDLE && scan_done)
            state_nx = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cursor_x    <= XW'(X_RST);
            cursor_y    <= YW'(Y_RST);
            color_q     <= 1'b0;
            x           <= '0;
            y           <= '0;
            pixel_color <= 1'b0;
            pixel_write <= 1'b0;
        end else begin
            if (accept) begin
                cursor_x <= cx_nx;
                cursor_y <= cy_nx;
                color_q  <= color_in;
            end
            if (state != IDLE) begin
                x           <= px[XW-1:0];
                y           <= py[YW-1:0];
                pixel_color <= state == STAMP && color_q;
            end
            pixel_write <= state != IDLE && px < X_LIM && py < Y_LIM;
        end
    end
endmodule

// File: tb/tb_cursor_brush.sv
// tb_cursor_brush: randomized self-checking bench for cursor_brush against a behavioural cursor/brush model.
module tb_cursor_brush;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [1:0] step_sel = 2'd0, brush_sel = 2'd0;
    logic draw_en = 1'b0, color_in = 1'b0, clear_req = 1'b0;
    logic [9:0] x, cursor_x;
    logic [8:0] y, cursor_y;
    logic pixel_color, pixel_write, busy;
    int total = 0;
    int bad = 0;
    int mx = 200;
    int my = 200;
    cursor_brush dut (
        .clk(clk), .reset_n(reset_n), .up(up), .down(down), .left(left), .right(right),
        .step_sel(step_sel), .brush_sel(brush_sel), .draw_en(draw_en), .color_in(color_in),
        .clear_req(clear_req), .x(x), .y(y), .pixel_color(pixel_color), .pixel_write(pixel_write),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
    );
    always #10 clk = ~clk;
    task automatic test_reset;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mx = 200;
        my = 200;
        total++;
        if (cursor_x !== 10'd200 || cursor_y !== 9'd200) begin
            bad++;
            $display("FAIL reset_cursor: got (%0d,%0d) want (200,200)", cursor_x, cursor_y);
        end
        total++;
        if ({busy, pixel_write, pixel_color, x, y} !== 22'd0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b wr=%b col=%b x=%0d y=%0d want all 0", busy, pixel_write, pixel_color, x, y);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask
    task automatic pulse_move(input bit u, d, l, r, input int ss, bs, input bit de, col, output int writes);
        int step, n, ex, ey;
        bit any, ew;
        step = ss == 0 ? 1 : ss == 1 ? 2 : ss == 2 ? 10 : 20;
        n = 1 << bs;
        writes = 0;
        @(negedge clk);
        up = u; down = d; left = l; right = r;
        step_sel = 2'(ss); brush_sel = 2'(bs); draw_en = de; color_in = col;
        @(posedge clk);
        #1;
        up = 0; down = 0; left = 0; right = 0;
        any = u | d | l | r;
        if (any) begin
            mx += (r ? step : 0) - (l ? step : 0);
            my += (d ? step : 0) - (u ? step : 0);
            mx = mx < 0 ? 0 : mx > 639 ? 639 : mx;
            my = my < 0 ? 0 : my > 479 ? 479 : my;
        end
        total++;
        if (cursor_x !== 10'(mx) || cursor_y !== 9'(my)) begin
            bad++;
            $display("FAIL move_cursor: got (%0d,%0d) want (%0d,%0d)", cursor_x, cursor_y, mx, my);
        end
        total++;
        if (busy !== (any && de) || pixel_write !== 1'b0) begin
            bad++;
            $display("FAIL move_status: busy=%b wr=%b want busy=%b wr=0", busy, pixel_write, any && de);
        end
        if (any && de) begin
            for (int k = 0; k < n * n; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    up = 1'($urandom); down = 1'($urandom); left = 1'($urandom); right = 1'($urandom);
                    step_sel = 2'($urandom); brush_sel = 2'($urandom);
                    draw_en = 1'($urandom); color_in = 1'($urandom);
                end
                @(posedge clk);
                #1;
                up = 0; down = 0; left = 0; right = 0;
                ex = mx + k % n;
                ey = my + k / n;
                ew = ex < 640 && ey < 480;
                if (pixel_write)
                    writes++;
                total++;
                if (pixel_write !== ew || pixel_color !== col || x !== 10'(ex) || y !== 9'(ey)) begin
                    bad++;
                    $display("FAIL stamp_pixel: k=%0d got wr=%b col=%b (%0d,%0d) want wr=%b col=%b (%0d,%0d)",
                             k, pixel_write, pixel_color, x, y, ew, col, ex, ey);
                end
                total++;
                if (busy !== (k < n * n - 1)) begin
                    bad++;
                    $display("FAIL stamp_busy: k=%0d got %b want %b", k, busy, k < n * n - 1);
                end
            end
            @(posedge clk);
            #1;
            total++;
            if (cursor_x !== 10'(mx) || cursor_y !== 9'(my) || busy !== 1'b0 || pixel_write !== 1'b0) begin
                bad++;
                $display("FAIL stamp_after: got (%0d,%0d) busy=%b wr=%b want (%0d,%0d) busy=0 wr=0",
                         cursor_x, cursor_y, busy, pixel_write, mx, my);
            end
        end
    endtask
    task automatic test_move_no_draw;
        int w;
        pulse_move(0, 0, 0, 1, 3, 0, 0, 0, w);
        total++;
        if (cursor_x !== 10'd220 || pixel_write !== 1'b0) begin
            bad++;
            $display("FAIL right_20: got x=%0d wr=%b want x=220 wr=0", cursor_x, pixel_write);
        end
    endtask
    task automatic test_clamp;
        int w;
        repeat (12) pulse_move(0, 0, 1, 0, 3, 0, 0, 0, w);
        repeat (10) pulse_move(1, 0, 0, 0, 3, 0, 0, 0, w);
        repeat (5) pulse_move(0, 1, 0, 1, 0, 0, 0, 0, w);
        pulse_move(1, 1, 0, 0, 3, 0, 0, 0, w);
        pulse_move(0, 0, 1, 1, 3, 0, 0, 0, w);
        total++;
        if (cursor_x !== 10'd5 || cursor_y !== 9'd5) begin
            bad++;
            $display("FAIL cancel_pairs: got (%0d,%0d) want (5,5)", cursor_x, cursor_y);
        end
        pulse_move(1, 0, 1, 0, 2, 0, 0, 0, w);
        total++;
        if (cursor_x !== 10'd0 || cursor_y !== 9'd0) begin
            bad++;
            $display("FAIL clamp_low: got (%0d,%0d) want (0,0)", cursor_x, cursor_y);
        end
        repeat (32) pulse_move(0, 0, 0, 1, 3, 0, 0, 0, w);
        repeat (4) pulse_move(0, 0, 1, 0, 0, 0, 0, 0, w);
        pulse_move(0, 0, 0, 1, 3, 0, 0, 0, w);
        total++;
        if (cursor_x !== 10'd639) begin
            bad++;
            $display("FAIL clamp_high: got x=%0d want 639", cursor_x);
        end
    endtask
    task automatic test_stamp_basic;
        int w;
        test_reset();
        pulse_move(0, 1, 0, 0, 1, 1, 1, 1, w);
        total++;
        if (w !== 4) begin
            bad++;
            $display("FAIL stamp_basic_writes: got %0d want 4", w);
        end
    endtask
    task automatic test_edge_clip;
        int w;
        repeat (22) pulse_move(0, 0, 0, 1, 3, 0, 0, 0, w);
        pulse_move(0, 0, 1, 0, 0, 0, 0, 0, w);
        repeat (14) pulse_move(0, 1, 0, 0, 3, 0, 0, 0, w);
        pulse_move(1, 0, 0, 0, 0, 2, 1, 1, w);
        total++;
        if (w !== 4) begin
            bad++;
            $display("FAIL edge_clip_writes: got %0d want 4", w);
        end
    endtask
    task automatic test_random;
        int w;
        repeat (60)
            pulse_move($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1), w);
    endtask
`ifdef CURSOR_BRUSH_CLEAR_EN
    task automatic test_clear;
        int w, err, c;
        @(negedge clk);
        clear_req = 1; right = 1; step_sel = 2'd3; draw_en = 1;
        @(posedge clk);
        #1;
        clear_req = 0; right = 0; draw_en = 0;
        total++;
        if (cursor_x !== 10'(mx) || cursor_y !== 9'(my) || busy !== 1'b1) begin
            bad++;
            $display("FAIL clear_start: got (%0d,%0d) busy=%b want (%0d,%0d) busy=1", cursor_x, cursor_y, busy, mx, my);
        end
        w = 0; err = 0; c = 0;
        while (busy && c < 307300) begin
            @(posedge clk);
            #1;
            c++;
            if (pixel_write) begin
                if (x !== 10'(w % 640) || y !== 9'(w / 640) || pixel_color !== 1'b0)
                    err++;
                w++;
            end
        end
        total++;
        if (w !== 307200 || err !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL clear_sweep: writes=%0d order_errs=%0d busy=%b want 307200/0/0", w, err, busy);
        end
        total++;
        if (x !== 10'd639 || y !== 9'd479 || pixel_write !== 1'b1) begin
            bad++;
            $display("FAIL clear_last: got (%0d,%0d) wr=%b want (639,479) wr=1", x, y, pixel_write);
        end
        @(negedge clk);
        clear_req = 1;
        @(posedge clk);
        #1;
        clear_req = 0;
        w = 0; c = 0;
        while (w < 1000 && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
            if (pixel_write)
                w++;
        end
        @(negedge clk);
        reset_n = 0;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || pixel_write !== 1'b0 || w !== 1000) begin
            bad++;
            $display("FAIL clear_abort: busy=%b wr=%b writes=%0d want 0/0/1000", busy, pixel_write, w);
        end
        @(negedge clk);
        reset_n = 1;
        mx = 200;
        my = 200;
    endtask
`else
    task automatic test_clear;
        @(negedge clk);
        clear_req = 1; right = 1; step_sel = 2'd0; draw_en = 0;
        @(posedge clk);
        #1;
        clear_req = 0; right = 0;
        mx = mx + 1 > 639 ? 639 : mx + 1;
        total++;
        if (busy !== 1'b0 || pixel_write !== 1'b0 || cursor_x !== 10'(mx)) begin
            bad++;
            $display("FAIL clear_ignored: busy=%b wr=%b x=%0d want 0/0/%0d", busy, pixel_write, cursor_x, mx);
        end
    endtask
`endif
    initial begin
        test_reset();
        test_move_no_draw();
        test_clamp();
        test_stamp_basic();
        test_edge_clip();
        test_random();
        test_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
